// File: rtl/floor_request_dispatcher.sv
// Elevator call-button front end: synchronises and latches floor buttons, then
// picks targets for the car controller with a direction-preserving SCAN policy.
module floor_request_dispatcher #(
   parameter int NUM_FLOORS   = 10,
   parameter int FLOOR_W      = 4,
   parameter int DWELL_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] btn_in,
   input  logic [FLOOR_W-1:0]    current_floor,
   output logic [FLOOR_W-1:0]    requested_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy,
   output logic                  dir_up,
   output logic                  arrived
);

   localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SERVE = 2'd1;
   localparam logic [1:0] S_DWELL = 2'd2;

   logic [NUM_FLOORS-1:0] r_sync1, r_sync2, r_prev, r_pending;
   logic [1:0]            r_state;
   logic [FLOOR_W-1:0]    r_req;
   logic                  r_dir_up, r_arrived;
   logic [CNT_W-1:0]      r_cnt;

   logic [NUM_FLOORS-1:0] w_press, w_cf_hot, w_req_hot, w_set, w_clr;
   logic                  w_up_found, w_dn_found, w_rt_up_found, w_rt_dn_found;
   logic [FLOOR_W-1:0]    w_up_floor, w_dn_floor, w_rt_up_floor, w_rt_dn_floor;
   logic [1:0]            w_nstate;
   logic [FLOOR_W-1:0]    w_nreq;
   logic                  w_ndir, w_arrive;

   assign w_press = r_sync2 & ~r_prev;

   // Nearest-pending searches: lowest above / highest below the car, and the
   // same restricted to the span between car and current target for retargeting.
   always_comb begin
      w_cf_hot      = '0;
      w_req_hot     = '0;
      w_up_found    = 1'b0;
      w_up_floor    = '0;
      w_dn_found    = 1'b0;
      w_dn_floor    = '0;
      w_rt_up_found = 1'b0;
      w_rt_up_floor = '0;
      w_rt_dn_found = 1'b0;
      w_rt_dn_floor = '0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         w_cf_hot[f]  = (int'(current_floor) == f);
         w_req_hot[f] = (int'(r_req) == f);
      end
      for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
         if (r_pending[f] && f > int'(current_floor)) begin
            w_up_found = 1'b1;
            w_up_floor = FLOOR_W'(f);
         end
         if (r_pending[f] && f > int'(current_floor) && f < int'(r_req)) begin
            w_rt_up_found = 1'b1;
            w_rt_up_floor = FLOOR_W'(f);
         end
      end
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (r_pending[f] && f < int'(current_floor)) begin
            w_dn_found = 1'b1;
            w_dn_floor = FLOOR_W'(f);
         end
         if (r_pending[f] && f < int'(current_floor) && f > int'(r_req)) begin
            w_rt_dn_found = 1'b1;
            w_rt_dn_floor = FLOOR_W'(f);
         end
      end
   end

   always_comb begin
      w_nstate = r_state;
      w_nreq   = r_req;
      w_ndir   = r_dir_up;
      w_arrive = 1'b0;
      w_clr    = '0;
      case (r_state)
         S_IDLE: begin
            if (r_pending != '0) begin
               if ((r_pending & w_cf_hot) != '0) begin
                  w_clr    = w_cf_hot;
                  w_nreq   = current_floor;
                  w_arrive = 1'b1;
                  w_nstate = S_DWELL;
               end else if (r_dir_up) begin
                  w_nstate = S_SERVE;
                  if (w_up_found) w_nreq = w_up_floor;
                  else begin
                     w_nreq = w_dn_floor;
                     w_ndir = 1'b0;
                  end
               end else begin
                  w_nstate = S_SERVE;
                  if (w_dn_found) w_nreq = w_dn_floor;
                  else begin
                     w_nreq = w_up_floor;
                     w_ndir = 1'b1;
                  end
               end
            end
         end
         S_SERVE: begin
            if (current_floor == r_req) begin
               w_clr    = w_req_hot;
               w_arrive = 1'b1;
               w_nstate = S_DWELL;
            end else if (r_dir_up && w_rt_up_found) begin
               w_nreq = w_rt_up_floor;
            end else if (!r_dir_up && w_rt_dn_found) begin
               w_nreq = w_rt_dn_floor;
            end
         end
         S_DWELL: begin
            if (r_cnt == CNT_W'(DWELL_CYCLES - 1)) w_nstate = S_IDLE;
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   // Calls for the floor the doors are open at are dropped; clear beats a same-edge press.
   assign w_set = w_press & ~((r_state == S_DWELL) ? w_cf_hot : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_prev    <= '0;
         r_pending <= '0;
         r_state   <= S_IDLE;
         r_req     <= '0;
         r_dir_up  <= 1'b1;
         r_arrived <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= btn_in;
         r_sync2   <= r_sync1;
         r_prev    <= r_sync2;
         r_pending <= (r_pending | w_set) & ~w_clr;
         r_state   <= w_nstate;
         r_req     <= w_nreq;
         r_dir_up  <= w_ndir;
         r_arrived <= w_arrive;
         r_cnt     <= (r_state == S_DWELL) ? r_cnt + 1'b1 : '0;
      end
   end

   assign requested_floor = r_req;
   assign pending         = r_pending;
   assign busy            = (r_state != S_IDLE);
   assign dir_up          = r_dir_up;
   assign arrived         = r_arrived;

endmodule

// File: tb/tb_floor_request_dispatcher.sv
// Directed bench for floor_request_dispatcher: expected arrival floors are queued
// by the stimulus and checked by an independent monitor on each arrived pulse.
module tb_floor_request_dispatcher;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] btn_in;
   logic [3:0] current_floor;
   logic [3:0] requested_floor;
   logic [9:0] pending;
   logic       busy, dir_up, arrived;

   int   comps = 0;
   int   errs  = 0;
   int   exp_q[$];

   floor_request_dispatcher #(.NUM_FLOORS(10), .FLOOR_W(4), .DWELL_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .current_floor(current_floor),
      .requested_floor(requested_floor), .pending(pending), .busy(busy),
      .dir_up(dir_up), .arrived(arrived)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int expv);
      comps++;
      if (act != expv) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // Scoreboard monitor: every arrival pulse must match the next queued floor.
   always @(negedge clk) begin
      if (arrived) begin
         comps++;
         if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_arrival: floor %0d, none expected", requested_floor);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(requested_floor) != e) begin
               errs++;
               $display("FAIL arrival_floor: got %0d expected %0d", requested_floor, e);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [9:0] m);
      btn_in = btn_in | m;
      tick(3);
      btn_in = btn_in & ~m;
   endtask

   // Car model: one floor per cycle toward the target while busy.
   task automatic step_car();
      if (busy && current_floor != requested_floor)
         current_floor = (requested_floor > current_floor) ? current_floor + 4'd1
                                                           : current_floor - 4'd1;
   endtask

   task automatic serve_all(input string nm);
      int n = 0;
      do begin
         tick();
         step_car();
         n++;
      end while ((pending != '0 || busy) && n < 2000);
      check({nm, "_done"}, int'(pending != '0 || busy), 0);
   endtask

   initial begin
      reset = 1'b1; btn_in = '0; current_floor = 4'd0;
      tick(3);
      check("rst_req", requested_floor, 0);
      check("rst_pending", pending, 0);
      check("rst_busy", busy, 0);
      check("rst_dir", dir_up, 1);
      check("rst_arrived", arrived, 0);
      reset = 1'b0;
      tick();

      // 1: single call, manual ramp
      exp_q.push_back(3);
      press(10'h008);
      check("t1_pending", pending, 10'h008);
      tick();
      check("t1_req", requested_floor, 3);
      check("t1_dir", dir_up, 1);
      check("t1_busy", busy, 1);
      current_floor = 1; tick();
      current_floor = 2; tick();
      check("t1_no_early_arr", arrived, 0);
      current_floor = 3; tick();
      check("t1_arrived", arrived, 1);
      check("t1_cleared", pending, 0);
      tick();
      check("t1_arr_one_cycle", arrived, 0);
      tick(6);
      check("t1_dwell_busy", busy, 1);
      tick();
      check("t1_dwell_end", busy, 0);

      // 2: SCAN ordering from floor 5 going up
      current_floor = 5;
      exp_q.push_back(7); exp_q.push_back(8); exp_q.push_back(2);
      press(10'h184);
      check("t2_pending", pending, 10'h184);
      tick();
      check("t2_first", requested_floor, 7);
      serve_all("t2");
      check("t2_dir", dir_up, 0);

      // 3: retarget toward a nearer floor ahead, not behind
      current_floor = 0;
      exp_q.push_back(4); exp_q.push_back(6); exp_q.push_back(1);
      press(10'h040);
      tick();
      check("t3_req6", requested_floor, 6);
      check("t3_dir", dir_up, 1);
      current_floor = 1; tick();
      current_floor = 2; tick();
      press(10'h010);
      check("t3_pre_retarget", requested_floor, 6);
      tick();
      check("t3_retarget", requested_floor, 4);
      press(10'h002);
      tick();
      check("t3_no_retarget", requested_floor, 4);
      check("t3_p1_kept", pending[1], 1);
      serve_all("t3");

      // 4: call at the car's own floor from IDLE, then during DWELL
      current_floor = 4;
      exp_q.push_back(4);
      press(10'h010);
      tick();
      check("t4_idle_arrive", arrived, 1);
      check("t4_idle_req", requested_floor, 4);
      check("t4_idle_pend", pending, 0);
      press(10'h010);
      check("t4_dwell_discard", pending, 0);
      tick(10);
      check("t4_idle_again", busy, 0);
      check("t4_still_clear", pending, 0);

      // 5a: long hold latches once
      exp_q.push_back(6);
      btn_in[6] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         step_car();
      end
      check("t5_hold_pending", pending, 0);
      check("t5_hold_busy", busy, 0);
      btn_in[6] = 1'b0;
      tick(4);

      // 5b: press lands on the arrival edge; clear wins
      current_floor = 3;
      exp_q.push_back(6);
      press(10'h040);
      tick();
      check("t5_req6", requested_floor, 6);
      btn_in[6] = 1'b1; current_floor = 4; tick();
      current_floor = 5; tick();
      current_floor = 6; tick();
      check("t5_coll_arrive", arrived, 1);
      check("t5_coll_clear", pending, 0);
      btn_in[6] = 1'b0;
      tick(10);
      check("t5_coll_after", pending, 0);

      // 6: reset during SERVE, with a button held through it
      current_floor = 5;
      press(10'h088);
      tick();
      check("t6_req7", requested_floor, 7);
      check("t6_pend", pending, 10'h088);
      btn_in[2] = 1'b1;
      reset = 1'b1;
      tick();
      check("t6_rst_req", requested_floor, 0);
      check("t6_rst_pend", pending, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_dir", dir_up, 1);
      check("t6_rst_arr", arrived, 0);
      tick();
      reset = 1'b0;
      tick(3);
      check("t6_held_press", pending, 10'h004);
      exp_q.push_back(2);
      serve_all("t6");
      btn_in[2] = 1'b0;
      check("t6_dir", dir_up, 0);

      // 7: out-of-range car floor still searches below
      current_floor = 15;
      exp_q.push_back(9);
      press(10'h200);
      tick();
      check("t7_req9", requested_floor, 9);
      serve_all("t7");

      tick(3);
      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
      $finish;
   end

endmodule

// File: doc/floor_request_dispatcher.md
Name: floor_request_dispatcher

Overview:
Call-button front end for the elevator controller. It drives the controller's requested_floor input and watches its current_floor output.
- Raw floor buttons are synchronised, edge-detected and latched into a pending-request register.
- Targets are chosen by a direction-preserving SCAN policy.
- A request is cleared when the car reaches its floor, followed by a door dwell.
- Sits between the board inputs and the elevator state machine.

Parameters:
NUM_FLOORS, 10, number of floors / button inputs (2..16)
FLOOR_W, 4, width of floor numbers
DWELL_CYCLES, 8, clk cycles spent in DWELL after each arrival (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
btn_in  input  NUM_FLOORS  raw asynchronous button levels, bit f = call for floor f
current_floor  input  FLOOR_W  present car floor from the elevator controller
requested_floor  output  FLOOR_W  target floor driven to the elevator controller
pending  output  NUM_FLOORS  latched outstanding requests
busy  output  1  high in SERVE and DWELL
dir_up  output  1  current sweep direction, 1 = up
arrived  output  1  one-cycle pulse when the target floor is reached

Behaviour:
- Reset (synchronous, active-high):
  - requested_floor=0, pending=0, busy=0, dir_up=1, arrived=0, state=IDLE.
  - Synchroniser and edge flops cleared; dwell counter cleared.
  - Reset mid-operation aborts everything the following edge.
  - A button held high through reset registers as one press after reset deasserts.
- Input path:
  - Per bit: 2-flop synchroniser, then a previous-value flop.
  - press[f] = sync2 & ~prev.
  - pending[f] sets on the 3rd rising edge after btn_in[f] rises (btn_in held >=3 cycles).
  - A held button does not re-trigger.
- States: IDLE, SERVE, DWELL.
- IDLE:
  - If pending==0: stay; requested_floor holds its last value.
  - Else if pending[current_floor]:
    - requested_floor=current_floor.
    - Clear that bit, pulse arrived, go to DWELL.
  - Else if dir_up:
    - Target = lowest pending floor > current_floor.
    - If none: target = highest pending floor < current_floor, and dir_up<=0.
  - Else (dir_up=0):
    - Target = highest pending floor < current_floor.
    - If none: target = lowest pending floor > current_floor, and dir_up<=1.
  - On a target: requested_floor<=target, go to SERVE. Decision and register update happen on the same edge.
- SERVE:
  - When current_floor==requested_floor: clear pending[requested_floor], arrived=1 for exactly one cycle, go to DWELL.
  - Retarget: if a pending floor lies strictly between current_floor and requested_floor in the travel direction, requested_floor<=the nearest such floor. This is evaluated every cycle.
  - Floors behind the car, or beyond the target, stay pending.
- DWELL:
  - Counter runs DWELL_CYCLES cycles, then go to IDLE (busy falls that edge).
  - Presses for current_floor during DWELL are discarded.
  - Presses for other floors are latched.
- Simultaneous events:
  - Clear and press of the same floor on the same edge: clear wins.
  - Press of a different floor on a clearing edge: it is set.
  - Several presses on one edge: all set.
- current_floor >= NUM_FLOORS: never matches a pending bit; above/below search still applies.
- requested_floor changes only in IDLE (target selection) or in SERVE (retarget); it is stable in DWELL.

Test Plan:
1. Reset, current_floor=0; press btn 3.
   - IDLE->SERVE; requested_floor=3, dir_up=1, busy=1.
   - Ramp current_floor 0..3: arrived pulses one cycle when it equals 3; pending[3]=0.
   - busy drops after 8 DWELL cycles.
2. SCAN order: current_floor=5, dir_up=1, pending {2,7,8}.
   - Targets served in order 7, 8, 2.
   - dir_up goes to 0 when 2 is selected.
   - pending=0 at the end.
3. Retarget: serving 0->6, current_floor=2.
   - Press 4: requested_floor becomes 4 on the edge after pending[4] sets.
   - Press 1: no retarget; pending[1] stays 1 and is served on the down sweep.
4. Current-floor presses:
   - In DWELL at floor 4, press 4: pending stays 0.
   - In IDLE at floor 4, press 4: requested_floor=4, arrived pulses, DWELL entered, no SERVE.
5. Edges and collisions:
   - btn 6 held high 50 cycles: pending[6] sets once, no re-latch after clear.
   - Press 6 on the same edge as arrival at 6: pending[6]=0.
6. Reset asserted mid-SERVE with pending {3,7}:
   - Next edge gives all outputs at reset values.
   - A button held through reset yields one press after release.
